// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD keypad entry block: FSM state codes,
// the BCD range limit and the 7-segment lookup table.
package bcd_entry_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    ACCEPT   = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    if (d > BCD_MAX) return SEG_BLANK;
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bcd_digit_entry_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes above 9 produce a dark digit.
module bcd_to_7seg
  import bcd_entry_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_seg(bcd);

endmodule

// File: rtl/bcd_digit_entry.sv
// Debounced BCD keypad entry register with multiplexed 7-segment scan output.
// Optional macro BCD_ENTRY_LEADING_ZERO_BLANK_EN blanks unused leading digits.
module bcd_digit_entry
  import bcd_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              bcd_in,
  input  logic                    key_valid,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              digit_count,
  output logic                    key_accept,
  output logic                    ovf,
  output logic                    err,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]        CNT_FULL  = 4'(NUM_DIGITS);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_DEBOUNCE = DEBOUNCE;
  localparam logic [2:0] S_ACCEPT   = ACCEPT;
  localparam logic [2:0] S_HELD     = HELD;
  localparam logic [2:0] S_RELEASE  = RELEASE;

  logic [2:0]       state;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_nxt;
  logic [3:0]       code_lat;
  logic             commit;
  logic             full;

  assign db_nxt = db_cnt + CNT_ONE;
  assign commit = (state == S_ACCEPT);
  assign full   = (digit_count == CNT_FULL);

  // Key debounce FSM: the same counter times both press and release stability
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      db_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_valid) begin
            code_lat <= bcd_in;
            db_cnt   <= CNT_ONE;
            state    <= (DB_LAST == CNT_ONE) ? S_ACCEPT : S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (!key_valid || (bcd_in != code_lat)) begin
            state <= S_IDLE;
          end else begin
            db_cnt <= db_nxt;
            if (db_nxt == DB_LAST) state <= S_ACCEPT;
          end
        end
        S_ACCEPT: state <= S_HELD;
        S_HELD: begin
          if (!key_valid) begin
            db_cnt <= CNT_ONE;
            state  <= (DB_LAST == CNT_ONE) ? S_IDLE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (key_valid) begin
            state <= S_HELD;
          end else begin
            db_cnt <= db_nxt;
            if (db_nxt == DB_LAST) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entry register: clr overrides any commit landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      digit_count <= '0;
      ovf         <= 1'b0;
      key_accept  <= 1'b0;
      err         <= 1'b0;
    end else begin
      key_accept <= 1'b0;
      err        <= 1'b0;
      if (commit) begin
        if (code_lat > BCD_MAX) begin
          err <= 1'b1;
        end else if (!clr) begin
          if (full) begin
            ovf <= 1'b1;
          end else begin
            digits      <= {digits[DW-5:0], code_lat};
            digit_count <= digit_count + 4'd1;
            key_accept  <= 1'b1;
          end
        end
      end
      if (clr) begin
        digits      <= '0;
        digit_count <= '0;
        ovf         <= 1'b0;
      end
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        scan_digit;
  logic [6:0]        dec_seg;
  logic              blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign scan_digit = digits[{scan_idx, 2'b00} +: 4];

`ifdef BCD_ENTRY_LEADING_ZERO_BLANK_EN
  assign blank = (scan_idx != '0) && (4'(scan_idx) >= digit_count);
`else
  assign blank = 1'b0;
`endif

  bcd_to_7seg u_bcd_to_7seg (
    .bcd (scan_digit),
    .seg (dec_seg)
  );

  // seg and an share one register stage so they switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= NUM_DIGITS'(1);
      seg <= SEG_LUT[0];
    end else begin
      an  <= NUM_DIGITS'(1) << scan_idx;
      seg <= blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Randomized self-checking bench for bcd_digit_entry against a press-level model.
module tb_bcd_digit_entry;

  localparam int ND = 4;
  localparam int DC = 4;
  localparam int SD = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      bcd_in = 4'd0;
  logic            key_valid = 1'b0;
  logic            clr = 1'b0;
  logic [4*ND-1:0] digits;
  logic [3:0]      digit_count;
  logic            key_accept;
  logic            ovf;
  logic            err;
  logic [6:0]      seg;
  logic [ND-1:0]   an;

  always #5 clk = ~clk;

  bcd_digit_entry #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DC),
    .SCAN_DIV        (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .key_valid   (key_valid),
    .clr         (clr),
    .digits      (digits),
    .digit_count (digit_count),
    .key_accept  (key_accept),
    .ovf         (ovf),
    .err         (err),
    .seg         (seg),
    .an          (an)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: list of entered digits, newest at index 0
  int         m_dig [ND];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       rst_d = 1'b1;
  logic       clr_d = 1'b0;
  int         ev_commit = -1;
  logic [3:0] ev_code = 4'd0;
  logic       disp_chk = 1'b0;
  logic [ND-1:0] last_an = '0;
  int         last_chg = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [31:0] model_digits();
    logic [31:0] r = 0;
    for (int i = 0; i < ND; i++) r = r | (32'(m_dig[i]) << (4 * i));
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic step(input logic kv, input logic [3:0] code, input logic c, input logic r);
    logic exp_acc;
    logic exp_err;
    logic [6:0] exp_seg;
    int p;
    @(negedge clk);
    cyc++;
    exp_acc = 1'b0;
    exp_err = 1'b0;
    if (rst_d) begin
      model_clear();
    end else begin
      if (cyc == ev_commit) begin
        if (ev_code > 4'd9) exp_err = 1'b1;
        else if (!clr_d) begin
          if (m_cnt == ND) m_ovf = 1'b1;
          else begin
            for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = int'(ev_code);
            m_cnt++;
            exp_acc = 1'b1;
          end
        end
      end
      if (clr_d) model_clear();
    end
    check_val("digits", 32'(digits), model_digits());
    check_val("digit_count", 32'(digit_count), 32'(m_cnt));
    check_val("key_accept", 32'(key_accept), 32'(exp_acc));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("ovf", 32'(ovf), 32'(m_ovf));
    if (disp_chk) begin
      p = -1;
      for (int i = 0; i < ND; i++) if (an[i]) p = i;
      check_val("an_onehot", 32'($onehot(an)), 32'd1);
      if (p >= 0) begin
        exp_seg = ref_seg(m_dig[p]);
`ifdef BCD_ENTRY_LEADING_ZERO_BLANK_EN
        if (p != 0 && p >= m_cnt) exp_seg = 7'h00;
`endif
        check_val("seg", 32'(seg), 32'(exp_seg));
      end
      if (an !== last_an) begin
        check_val("an_rotate", 32'(an), 32'({last_an[ND-2:0], last_an[ND-1]}));
        if (last_chg >= 0) check_val("scan_period", 32'(cyc - last_chg), 32'(SD));
        last_chg = cyc;
        last_an  = an;
      end
    end
    key_valid = kv;
    bcd_in    = code;
    clr       = c;
    rst       = r;
    rst_d     = r;
    clr_d     = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  // hold cycles high, optional short dropout after acceptance, then release
  task automatic press(input logic [3:0] code, input int hold, input int gap,
                       input int rel, input int clr_at);
    if (hold >= DC) begin
      ev_commit = cyc + 1 + DC + 1;
      ev_code   = code;
    end
    for (int i = 0; i < hold; i++) step(1'b1, code, (i == clr_at), 1'b0);
    if (gap > 0) begin
      for (int g = 0; g < gap; g++) step(1'b0, code, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) step(1'b1, code, 1'b0, 1'b0);
    end
    idle(rel);
  endtask

  initial begin
    int op;
    int hold;
    int gap;
    logic [3:0] code;

    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
    idle(2);
    check_val("rst_an", 32'(an), 32'd1);
    check_val("rst_seg", 32'(seg), 32'h3F);

    press(4'd1, 10, 0, 10, -1);
    check_val("first_digit", 32'(digits), 32'h1);
    press(4'd7, 2, 0, 8, -1);
    press(4'd2, 8, 0, 8, -1);
    press(4'd3, 8, 0, 8, -1);
    press(4'd4, 8, 0, 8, -1);
    press(4'd5, 8, 0, 8, -1);
    check_val("full_digits", 32'(digits), 32'h1234);
    check_val("full_ovf", 32'(ovf), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(2);
    check_val("clr_digits", 32'(digits), 32'h0);

    press(4'hC, 10, 0, 8, -1);
    press(4'd8, 8, 0, 8, -1);
    press(4'd6, 12, 0, 8, DC);
    press(4'd8, 8, 0, 8, -1);
    press(4'd6, 12, 0, 8, DC + 3);
    press(4'd3, DC + 4, 2, 8, -1);

    // Reset while a key is held: the still-held key is a fresh press
    press(4'd9, 10, 0, 0, -1);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    press(4'd9, 10, 0, 8, -1);
    check_val("rst_hold", 32'(digits), 32'h9);

    step(1'b0, 4'd0, 1'b1, 1'b0);
    press(4'd4, 8, 0, 8, -1);
    press(4'd2, 8, 0, 8, -1);
    check_val("disp_digits", 32'(digits), 32'h42);
    last_an  = an;
    last_chg = -1;
    disp_chk = 1'b1;
    idle(2 * ND * SD + 5);
    disp_chk = 1'b0;

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        code = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        hold = int'($urandom_range(DC, DC + 8));
        gap  = (hold >= DC + 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, DC - 1)) : 0;
        press(code, hold, gap, int'($urandom_range(DC + 2, DC + 6)), -1);
      end else if (op <= 7) begin
        press(4'($urandom_range(0, 15)), int'($urandom_range(1, DC - 1)), 0,
              int'($urandom_range(DC + 2, DC + 5)), -1);
      end else if (op == 8) begin
        step(1'b0, 4'd0, 1'b1, 1'b0);
        idle(1);
      end else begin
        idle(int'($urandom_range(1, 6)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
